// File: rtl/mux2_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux2_pkg
// Shared definitions for the two-requester packet arbiter around Mux_2.
//   DEFAULT_WIDTH : beat width used by Mux_2 and the arbiter unless overridden
//   state_e       : arbiter grant state (IDLE, GRANT0, GRANT1)
// ----------------------------------------------------------------------------
package mux2_pkg;

  localparam int DEFAULT_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux2_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux2_arbiter_if
// Bundles the two requester handshakes, the registered output stage and the
// status outputs of mux2_arbiter.
//   slave  modport : arbiter side (consumes requests, drives output stage)
//   master modport : environment side (drives requests and out_ready)
// ----------------------------------------------------------------------------
interface mux2_arbiter_if
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;
  logic             sel;
  logic             overrun;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_last, out_src,
    output sel, overrun
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_last, out_src,
    input  sel, overrun
  );

endinterface

// File: rtl/mux2_arbiter_mux2.sv
// ----------------------------------------------------------------------------
// Mux_2
// Two-input WIDTH-bit data multiplexer shared by the two requesters.
//   S  : select (0 = K0, 1 = K1)
//   K0 : input 0
//   K1 : input 1
//   Y  : selected data
// ----------------------------------------------------------------------------
module Mux_2
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             S,
  input  logic [WIDTH-1:0] K0,
  input  logic [WIDTH-1:0] K1,
  output logic [WIDTH-1:0] Y
);

  // Data select.
  always_comb begin
    Y = K0;
    if (S) begin
      Y = K1;
    end else begin
      Y = K0;
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// ----------------------------------------------------------------------------
// mux2_arbiter
// Round-robin packet arbiter sharing one Mux_2 between two requesters. The
// grant is held for a whole packet (or MAX_BEATS beats, whichever comes
// first) and the selected beat is registered into a single output stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux2_arbiter_if.slave -- request handshakes, output stage,
//           sel (current mux select) and sticky overrun flag
// ----------------------------------------------------------------------------
module mux2_arbiter
  import mux2_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mux2_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_src_q, out_src_d;
  logic               overrun_q, overrun_d;

  logic               sel_s;
  logic               granted_s;
  logic               stage_free_s;
  logic               valid_sel_s;
  logic               last_sel_s;
  logic               xfer_s;
  logic               cap_s;
  logic [WIDTH-1:0]   mux_y_s;

  Mux_2 #(.WIDTH(WIDTH)) u_mux (
    .S  (sel_s),
    .K0 (bus.req0_data),
    .K1 (bus.req1_data),
    .Y  (mux_y_s)
  );

  // Grant decode, local last/valid select and beat-transfer qualifier.
  always_comb begin
    sel_s        = (state_q == GRANT1);
    granted_s    = (state_q == GRANT0) || (state_q == GRANT1);
    // The output stage can take a beat if it is empty or draining this cycle.
    stage_free_s = !out_valid_q || bus.out_ready;
    if (sel_s) begin
      valid_sel_s = bus.req1_valid;
      last_sel_s  = bus.req1_last;
    end else begin
      valid_sel_s = bus.req0_valid;
      last_sel_s  = bus.req0_last;
    end
    xfer_s = granted_s && valid_sel_s && stage_free_s;
    // Counter holds beats already taken, so the MAX_BEATS-th beat sees MAX_BEATS-1.
    cap_s  = (cnt_q == CNT_W'(MAX_BEATS - 1));
  end

  // Next grant state, beat counter, priority pointer and overrun flag.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_d = ptr_q ? GRANT1 : GRANT0;
        end else if (bus.req0_valid) begin
          state_d = GRANT0;
        end else if (bus.req1_valid) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer_s) begin
          if (last_sel_s || cap_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = !sel_s;
            if (!last_sel_s) begin
              overrun_d = 1'b1;
            end else begin
              overrun_d = overrun_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: load on transfer, otherwise drain when downstream accepts.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y_s;
      out_last_d  = last_sel_s;
      out_src_d   = sel_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      overrun_q   <= overrun_d;
    end
  end

  // Readies depend only on the grant and the output stage, never on req*_valid.
  assign bus.req0_ready = (state_q == GRANT0) && stage_free_s;
  assign bus.req1_ready = (state_q == GRANT1) && stage_free_s;
  assign bus.sel        = sel_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_src    = out_src_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin packet arbiter that shares the 20-bit `Mux_2` datapath between two requesters. Each requester presents 20-bit beats with a valid/ready handshake and a `last` marker. The block drives the mux select, locks the grant for a whole packet, and registers the selected beat into a single output stage. It sits between the two key/data sources and the downstream 20-bit consumer.

## Interface
- `WIDTH`, default 20: beat width; must match the `Mux_2` data width.
- `MAX_BEATS`, default 16: maximum beats per grant before a forced release; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester 0/1 has a beat.
- `req0_data` / `req1_data`  in  WIDTH  requester 0/1 beat.
- `req0_last` / `req1_last`  in  1  beat is the final beat of the packet.
- `req0_ready` / `req1_ready`  out  1  beat accepted this cycle when valid & ready.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  registered beat.
- `out_last`  out  1  registered last flag.
- `out_src`  out  1  source of the registered beat (0/1).
- `out_ready`  in  1  downstream accepts the beat.
- `sel`  out  1  current mux select (0 = req0, 1 = req1); equals the granted requester.
- `overrun`  out  1  sticky; set on a forced release; cleared only by reset.

## Operation
- States: IDLE, GRANT0, GRANT1. Reset state is IDLE.
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `sel`=0, `overrun`=0, `req*_ready`=0, priority pointer=0, beat counter=0.
- IDLE:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester named by the priority pointer.
  - If neither is valid, stay in IDLE.
  - Grant takes effect at the next edge (IDLE→GRANTx).
- GRANTx:
  - `sel`=x.
  - `reqx_ready` = `!out_valid || out_ready`. The other requester's ready is 0.
  - In IDLE both readies are 0.
- Beat transfer (valid & ready):
  - Loads `out_data`/`out_last`/`out_src` from the mux output, sets `out_valid`=1, and increments the beat counter.
- Release (GRANTx→IDLE, counter←0, pointer←!x) happens on either:
  - transfer of a beat with `last`=1; or
  - transfer of beat number `MAX_BEATS` without `last`. This is a forced release: `overrun`←1 and the packet is split.
- Output stage: `out_valid` clears when `out_ready`=1 and no new beat loads in the same cycle. A simultaneous drain and load keeps `out_valid`=1 with the new beat.
- Packet integrity: beats from different requesters never interleave within a grant.
- Reset asserted mid-packet: all state clears immediately. The in-flight beat is lost; no partial recovery.

## Timing
- Arbitration decision: 1 cycle (IDLE→GRANT).
- Beat latency: input accepted at edge N appears on `out_*` after edge N.
- First beat of a packet: earliest on the output 2 cycles after `valid` rises with the block in IDLE.
- Throughput within a grant: 1 beat/cycle while `out_ready`=1.
- Between packets: exactly one IDLE cycle, including on a forced release.
- `req*_ready` and `sel` are functions of registered state plus `out_valid`/`out_ready`. No path from `req*_valid` to `req*_ready`.
- Backpressure: with `out_ready`=0 and `out_valid`=1, the granted requester's ready is 0 and the output holds stable.

## Structure
- Shared package `mux2_pkg`:
  - state enum (IDLE, GRANT0, GRANT1);
  - `WIDTH` default constant 20.
- Instantiates one `Mux_2`:
  - `S`=`sel`, `K0`=`req0_data`, `K1`=`req1_data`, `Y` feeds the output register.
  - `last` is selected locally with the same select.
- Beat counter width is `$clog2(MAX_BEATS+1)`.

## Test plan
- **Single packet:** req0 sends 3 beats (0x00001, 0x00002, 0x00003 with `last`), `out_ready`=1 → `out_data` shows 0x00001..0x00003 on consecutive cycles, `out_src`=0, first beat 2 cycles after valid.
- **Contention:** both valid in IDLE after reset, each sending 1-beat packets repeatedly → grants alternate 0,1,0,1 with one IDLE cycle between packets.
- **Backpressure:** `out_ready`=0 for 4 cycles mid-packet → `out_data` holds and `req_ready`=0; on `out_ready`=1 the stream resumes with no beat lost or duplicated.
- **Forced release:** `MAX_BEATS`=4, req1 sends 6 beats with `last` only on beat 6 → grant drops after beat 4, `overrun`=1, req0 (pending) is served next.
- **Reset mid-packet:** `rst_n` low during beat 2 → all outputs return to reset values asynchronously. After release, a new packet from req1 is granted first only if req0 is idle.
- **Simultaneous drain/load:** `out_valid`=1, `out_ready`=1 and a new valid beat in the same cycle → `out_valid` stays 1 and `out_data` updates to the new beat.
